// File: rtl/ssim_stream_ctrl.sv
// ssim_stream_ctrl: frame sequencer for the streaming SSIM sigma datapath.
// Carries valid/last tags alongside the fixed-latency pipe and flushes it with zero beats.
module ssim_stream_ctrl #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int PIPE_LATENCY    = 70
) (
    input  logic clk,
    input  logic aresetn,
    input  logic start,
    input  logic s_valid,
    input  logic s_last,
    output logic s_ready,
    output logic m_valid,
    output logic m_last,
    input  logic m_ready,
    output logic dp_stall,
    output logic dp_aresetn,
    output logic dp_zero_in,
    output logic busy,
    output logic frame_done,
    output logic err_last
);
    localparam int BEATS = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int BW    = $clog2(BEATS + 1);
    localparam int FW    = $clog2(PIPE_LATENCY + 1);

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
    localparam logic [FW-1:0] FLUSH_MAX = FW'(PIPE_LATENCY);
    localparam logic [FW-1:0] FLUSH_ONE = FW'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]              state_r;
    logic [1:0]              state_nxt_s;
    logic [BW-1:0]           beat_cnt_r;
    logic [FW-1:0]           flush_cnt_r;
    logic [PIPE_LATENCY-1:0] vtag_r;
    logic [PIPE_LATENCY-1:0] ltag_r;
    logic                    dp_aresetn_r;
    logic                    err_last_r;

    logic is_idle_s;
    logic is_run_s;
    logic is_flush_s;
    logic starve_s;
    logic hold_s;
    logic adv_s;
    logic accept_s;
    logic last_beat_s;

    assign is_idle_s   = (state_r == ST_IDLE);
    assign is_run_s    = (state_r == ST_RUN);
    assign is_flush_s  = (state_r == ST_FLUSH);
    assign starve_s    = is_run_s & ~s_valid;
    assign last_beat_s = (beat_cnt_r == LAST_BEAT);

    // The output beat is withheld while the pipe is starved, so every output
    // handshake coincides with an advance and no tag is lost or duplicated.
    assign m_valid    = vtag_r[PIPE_LATENCY-1] & ~starve_s;
    assign m_last     = ltag_r[PIPE_LATENCY-1] & ~starve_s;
    assign hold_s     = m_valid & ~m_ready;
    assign dp_stall   = hold_s | starve_s | is_idle_s;
    assign adv_s      = ~dp_stall;
    assign s_ready    = is_run_s & ~hold_s;
    assign accept_s   = s_valid & s_ready;

    assign dp_aresetn = dp_aresetn_r;
    assign dp_zero_in = is_flush_s;
    assign busy       = ~is_idle_s;
    assign frame_done = is_flush_s & m_last & m_ready;
    assign err_last   = err_last_r;

    // Next-state selection for the frame sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && last_beat_s) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (m_last && m_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register; datapath reset releases together with the first RUN cycle.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_r      <= ST_IDLE;
            dp_aresetn_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            dp_aresetn_r <= (state_nxt_s != ST_IDLE);
        end
    end

    // Input beat counter and flush advance counter.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt_r  <= {BW{1'b0}};
            flush_cnt_r <= {FW{1'b0}};
        end else begin
            if (is_idle_s && start) begin
                beat_cnt_r <= {BW{1'b0}};
            end else if (accept_s) begin
                beat_cnt_r <= beat_cnt_r + BEAT_ONE;
            end
            if (accept_s && last_beat_s) begin
                flush_cnt_r <= {FW{1'b0}};
            end else if (is_flush_s && adv_s && (flush_cnt_r != FLUSH_MAX)) begin
                flush_cnt_r <= flush_cnt_r + FLUSH_ONE;
            end
        end
    end

    // Valid/last tag pipes mirror the datapath and move only when it advances.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            vtag_r <= {PIPE_LATENCY{1'b0}};
            ltag_r <= {PIPE_LATENCY{1'b0}};
        end else if (adv_s) begin
            vtag_r <= {vtag_r[PIPE_LATENCY-2:0], accept_s};
            ltag_r <= {ltag_r[PIPE_LATENCY-2:0], accept_s & last_beat_s};
        end
    end

    // Sticky s_last mismatch; the beat count alone terminates the frame.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            err_last_r <= 1'b0;
        end else if (is_idle_s && start) begin
            err_last_r <= 1'b0;
        end else if (accept_s && (s_last != last_beat_s)) begin
            err_last_r <= 1'b1;
        end
    end
endmodule

// File: doc/ssim_stream_ctrl.md
SSIM_STREAM_CTRL -- requirements
Module: ssim_stream_ctrl

Interface
REQ-001 SHALL have parameter PIXELS_PER_BEAT, default 16: pixels per beat.
REQ-002 SHALL have parameter IMAGE_DIM, default 512: image width and height in pixels.
REQ-003 SHALL have parameter PIPE_LATENCY, default 70: advancing cycles from datapath input to matching datapath output (≥2).
REQ-004 SHALL derive localparam BEATS = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT; counter widths = clog2(BEATS+1) and clog2(PIPE_LATENCY+1).
REQ-005 SHALL have clk  in  1  sole clock; all flops on rising edge.
REQ-006 SHALL have aresetn  in  1  asynchronous active-low reset.
REQ-007 SHALL have start  in  1  one-cycle frame start request, honoured only in IDLE.
REQ-008 SHALL have s_valid  in  1  input pixel beat (x,y pair) available.
REQ-009 SHALL have s_last  in  1  input marks final beat of frame.
REQ-010 SHALL have s_ready  out  1  input beat accepted when s_valid&s_ready.
REQ-011 SHALL have m_valid  out  1  datapath output beat valid.
REQ-012 SHALL have m_last  out  1  final output beat of frame.
REQ-013 SHALL have m_ready  in  1  downstream accepts output beat.
REQ-014 SHALL have dp_stall  out  1  stall to the sigma datapath.
REQ-015 SHALL have dp_aresetn  out  1  datapath reset, active-low.
REQ-016 SHALL have dp_zero_in  out  1  datapath input mux selects zeros (flush beats).
REQ-017 SHALL have busy  out  1  state != IDLE.
REQ-018 SHALL have frame_done  out  1  one-cycle pulse at frame completion.
REQ-019 SHALL have err_last  out  1  sticky s_last/beat-count mismatch flag.

Function
REQ-020 SHALL implement states IDLE, RUN, FLUSH.
REQ-021 SHALL define hold = m_valid & ~m_ready; adv = ~dp_stall.
REQ-022 SHALL drive dp_stall = hold | (RUN & ~s_valid) | IDLE.
REQ-023 SHALL drive s_ready = RUN & ~hold; accept = s_valid & s_ready.
REQ-024 SHALL hold dp_aresetn low (registered) while in IDLE, high in RUN/FLUSH; it rises the cycle after leaving IDLE.
REQ-025 SHALL keep a PIPE_LATENCY-deep valid-tag shift register and a parallel last-tag shift register, both shifting only when adv.
REQ-026 SHALL shift in valid-tag = accept, last-tag = accept & (beat_cnt==BEATS-1); in FLUSH shift in 0/0.
REQ-027 SHALL drive m_valid/m_last from the final tag stages; m_valid holds stable while hold.
REQ-028 SHALL transition IDLE->RUN on start; beat_cnt cleared to 0.
REQ-029 SHALL increment beat_cnt on accept; on accept with beat_cnt==BEATS-1, transition RUN->FLUSH and clear flush_cnt.
REQ-030 SHALL assert dp_zero_in in FLUSH; flush_cnt increments on adv.
REQ-031 SHALL leave FLUSH for IDLE when m_last&m_ready (final output handed off); frame_done pulses that cycle.
REQ-032 SHALL set err_last when accept and s_last != (beat_cnt==BEATS-1); beat count, not s_last, terminates the frame.
REQ-033 SHALL ignore start outside IDLE; start coincident with frame_done is ignored.
REQ-034 SHALL tolerate m_ready low indefinitely in any state without tag loss or duplication.
REQ-035 SHALL clear err_last only on reset or start accepted in IDLE.

Reset
REQ-036 SHALL on aresetn low immediately: state IDLE, all tags 0, counters 0, m_valid 0, m_last 0, s_ready 0, dp_stall 1, dp_aresetn 0, dp_zero_in 0, busy 0, frame_done 0, err_last 0.
REQ-037 SHALL abandon any frame when reset asserts mid-RUN/FLUSH; no m_valid after release until a new start.

Verification (PIXELS_PER_BEAT=4, IMAGE_DIM=8, BEATS=16, PIPE_LATENCY=5)
REQ-038 SHALL verify: start, s_valid=1 for 16 cycles, m_ready=1 -> m_valid first high 5 advances after first accept, 16 consecutive output beats, m_last on 16th, frame_done next to it, state IDLE.
REQ-039 SHALL verify: s_valid low cycles 3-6 -> dp_stall high those cycles, output still exactly 16 beats, no gaps caused beyond input gaps.
REQ-040 SHALL verify: m_ready low 4 cycles while m_valid=1 -> s_ready=0, dp_stall=1, m_valid/m_last stable, no beat lost.
REQ-041 SHALL verify: s_last asserted on beat 10 -> err_last=1 sticky, frame still ends after beat 16.
REQ-042 SHALL verify: aresetn pulsed low at beat 8 -> all outputs at reset values at once; after release, no m_valid until start.
REQ-043 SHALL verify: start asserted during RUN and with frame_done -> ignored; second frame after IDLE runs normally.
